// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter defaults and checker state encoding
package counter_pkg;

    localparam int CNT_W_DEF   = 4;
    localparam int MAX_VAL_DEF = 15;

    typedef enum logic [1:0] {ARM, SYNC, TRACK, FAIL} chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - checks a wrapping counter sequence, tallies wraps, latches first error
module count_seq_checker
    import counter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  count,
    input  logic              clear_err,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_total,
    output logic              err,
    output logic [CNT_W-1:0]  err_exp,
    output logic [CNT_W-1:0]  err_got
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_VAL);

    chk_state_t       r_state;
    logic [CNT_W-1:0] r_prev;
    logic             r_locked;
    logic             r_wrap_pulse;
    logic             r_err;
    logic [CNT_W-1:0] r_err_exp;
    logic [CNT_W-1:0] r_err_got;

    chk_state_t       w_next;
    logic [CNT_W-1:0] w_exp;
    logic             w_match;
    logic             w_wrap;

    assign w_exp   = (r_prev == LP_MAX) ? '0 : r_prev + 1'b1;
    assign w_match = (count == w_exp);
    assign w_wrap  = (r_state == TRACK) && w_match && (r_prev == LP_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARM:     w_next = (count == '0) ? TRACK : FAIL;
            TRACK:   w_next = w_match ? TRACK : FAIL;
            FAIL:    w_next = clear_err ? SYNC : FAIL;
            SYNC:    w_next = TRACK;
            default: w_next = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARM;
            r_prev       <= '0;
            r_locked     <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err        <= 1'b0;
            r_err_exp    <= '0;
            r_err_got    <= '0;
        end else begin
            r_state      <= w_next;
            r_locked     <= (w_next == TRACK);
            r_wrap_pulse <= w_wrap;
            case (r_state)
                ARM: begin
                    if (count == '0) begin
                        r_prev <= count;
                    end else begin
                        r_err     <= 1'b1;
                        r_err_exp <= '0;
                        r_err_got <= count;
                    end
                end
                TRACK: begin
                    if (w_match) begin
                        r_prev <= count;
                    end else begin
                        r_err     <= 1'b1;
                        r_err_exp <= w_exp;
                        r_err_got <= count;
                    end
                end
                FAIL: begin
                    // error capture stays visible after clearing for post-mortem
                    if (clear_err) begin
                        r_err <= 1'b0;
                    end
                end
                SYNC: begin
                    r_prev <= count;
                end
                default: begin
                    r_prev <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wrap_tally (
        .clk (clk),
        .rst (rst),
        .en  (w_wrap),
        .q   (wrap_total)
    );

    assign locked     = r_locked;
    assign wrap_pulse = r_wrap_pulse;
    assign err        = r_err;
    assign err_exp    = r_err_exp;
    assign err_got    = r_err_got;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - scoreboard bench for count_seq_checker
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_err = 1'b0;
    logic [3:0] count = 4'd0;

    logic       locked, wrap_pulse, err;
    logic [7:0] wrap_total;
    logic [3:0] err_exp, err_got;

    logic       locked2, wrap_pulse2, err2;
    logic [1:0] wrap_total2;
    logic [3:0] err_exp2, err_got2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       locked;
        logic       pulse;
        logic [7:0] total;
        logic [1:0] total2;
        logic       err;
        logic [3:0] eexp;
        logic [3:0] egot;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    count_seq_checker #(.CNT_W(4), .MAX_VAL(15), .WRAP_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .clear_err  (clear_err),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .wrap_total (wrap_total),
        .err        (err),
        .err_exp    (err_exp),
        .err_got    (err_got)
    );

    // narrow tally copy: shares stimulus, only wrap_total width differs
    count_seq_checker #(.CNT_W(4), .MAX_VAL(15), .WRAP_W(2)) u_dut_sat (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .clear_err  (clear_err),
        .locked     (locked2),
        .wrap_pulse (wrap_pulse2),
        .wrap_total (wrap_total2),
        .err        (err2),
        .err_exp    (err_exp2),
        .err_got    (err_got2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic [3:0] cnt,
                        input logic lk, input logic p, input logic [7:0] t,
                        input logic e, input logic [3:0] ee, input logic [3:0] eg);
        exp_t x;
        @(negedge clk);
        rst       = r;
        clear_err = c;
        count     = cnt;
        x.locked  = lk;
        x.pulse   = p;
        x.total   = t;
        x.total2  = (t > 8'd3) ? 2'd3 : t[1:0];
        x.err     = e;
        x.eexp    = ee;
        x.egot    = eg;
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("locked",      32'(locked),      32'(x.locked));
                chk("wrap_pulse",  32'(wrap_pulse),  32'(x.pulse));
                chk("wrap_total",  32'(wrap_total),  32'(x.total));
                chk("err",         32'(err),         32'(x.err));
                chk("err_exp",     32'(err_exp),     32'(x.eexp));
                chk("err_got",     32'(err_got),     32'(x.egot));
                chk("sat_pulse",   32'(wrap_pulse2), 32'(x.pulse));
                chk("sat_total",   32'(wrap_total2), 32'(x.total2));
                chk("sat_locked",  32'(locked2),     32'(x.locked));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // reset held for three cycles
        for (int i = 0; i < 3; i++) step(1, 0, 4'd0, 0, 0, 8'd0, 0, 4'd0, 4'd0);

        // free run with 15->0 wraps; clear_err at i==20 must be ignored; ends at count 12
        for (int i = 0; i <= 92; i++)
            step(0, (i == 20), 4'(i % 16), 1, (i > 0 && i % 16 == 0), 8'(i / 16), 0, 4'd0, 4'd0);

        // counter and checker reset together mid-count
        step(1, 0, 4'd13, 0, 0, 8'd0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd0,  1, 0, 8'd0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd1,  1, 0, 8'd0, 0, 4'd0, 4'd0);

        // nonzero first sample after reset
        step(1, 0, 4'd0, 0, 0, 8'd0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd5, 0, 0, 8'd0, 1, 4'd0, 4'd5);
        step(0, 0, 4'd6, 0, 0, 8'd0, 1, 4'd0, 4'd5);

        // reset wins over clear_err while in FAIL
        step(1, 1, 4'd0, 0, 0, 8'd0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd0, 1, 0, 8'd0, 0, 4'd0, 4'd0);
        for (int k = 1; k <= 23; k++)
            step(0, 0, 4'(k % 16), 1, (k == 16), 8'(k / 16), 0, 4'd0, 4'd0);

        // skip from 7 to 9: capture 8/9, tally frozen at 1
        step(0, 0, 4'd9,  0, 0, 8'd1, 1, 4'd8, 4'd9);
        step(0, 0, 4'd10, 0, 0, 8'd1, 1, 4'd8, 4'd9);
        step(0, 0, 4'd0,  0, 0, 8'd1, 1, 4'd8, 4'd9);

        // clear and resync at 3, then track 4.. through a wrap
        step(0, 1, 4'd3, 0, 0, 8'd1, 0, 4'd8, 4'd9);
        for (int k = 4; k <= 17; k++)
            step(0, 0, 4'(k % 16), 1, (k == 16), (k >= 16) ? 8'd2 : 8'd1, 0, 4'd8, 4'd9);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
